// File: rtl/bp_l15_pkg.sv
// Shared types and constants for the L1.5 fill encoder: packet layouts,
// cache-memory opcodes and the L1.5 return type that carries a line fill.
package bp_l15_pkg;

    localparam int INDEX_W = 6;
    localparam int TAG_W   = 28;
    localparam int WAY_W   = 3;
    localparam int LINE_W  = 512;
    localparam int BEAT_W  = 128;

    localparam logic [3:0] LOAD_RET     = 4'b0000;
    localparam logic [1:0] DATA_WRITE   = 2'b01;
    localparam logic [1:0] TAG_SET      = 2'b10;
    localparam logic [1:0] STAT_SET_LRU = 2'b11;
    localparam logic [2:0] COH_E        = 3'b010;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        SEND      = 2'd2
    } fill_state_e;

    typedef struct packed {
        logic [1:0]         opcode;
        logic [INDEX_W-1:0] index;
        logic [WAY_W-1:0]   way;
        logic [LINE_W-1:0]  line;
    } data_mem_pkt_s;

    typedef struct packed {
        logic [1:0]         opcode;
        logic [INDEX_W-1:0] index;
        logic [WAY_W-1:0]   way;
        logic [2:0]         state;
        logic [TAG_W-1:0]   tag;
    } tag_mem_pkt_s;

    typedef struct packed {
        logic [1:0]         opcode;
        logic [INDEX_W-1:0] index;
        logic [WAY_W-1:0]   way;
    } stat_mem_pkt_s;

endpackage

// File: rtl/bp_l15_fill_encoder_if.sv
// The three cache-memory packet channels (packet, valid, yumi) as one bundle.
interface bp_l15_fill_encoder_if;
    import bp_l15_pkg::*;

    data_mem_pkt_s data_pkt;
    logic          data_v;
    logic          data_yumi;
    tag_mem_pkt_s  tag_pkt;
    logic          tag_v;
    logic          tag_yumi;
    stat_mem_pkt_s stat_pkt;
    logic          stat_v;
    logic          stat_yumi;

    modport master (
        output data_pkt, data_v, tag_pkt, tag_v, stat_pkt, stat_v,
        input  data_yumi, tag_yumi, stat_yumi
    );

    modport slave (
        input  data_pkt, data_v, tag_pkt, tag_v, stat_pkt, stat_v,
        output data_yumi, tag_yumi, stat_yumi
    );

endinterface

// File: rtl/bp_l15_pkt_issue.sv
// Valid/yumi tracker for the data, tag and stat packet channels: all three
// valids rise together on start and each drops after its own yumi.
module bp_l15_pkt_issue
    import bp_l15_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  data_mem_pkt_s                data_pkt,
    input  tag_mem_pkt_s                 tag_pkt,
    input  stat_mem_pkt_s                stat_pkt,
    output logic                         done,
    bp_l15_fill_encoder_if.master        mem
);

    logic data_v;
    logic tag_v;
    logic stat_v;
    logic data_left;
    logic tag_left;
    logic stat_left;

    // A yumi only retires a channel whose valid is currently high.
    assign data_left = data_v & ~mem.data_yumi;
    assign tag_left  = tag_v  & ~mem.tag_yumi;
    assign stat_left = stat_v & ~mem.stat_yumi;

    assign done = (data_v | tag_v | stat_v) & ~(data_left | tag_left | stat_left);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_v <= 1'b0;
            tag_v  <= 1'b0;
            stat_v <= 1'b0;
        end else if (start) begin
            data_v <= 1'b1;
            tag_v  <= 1'b1;
            stat_v <= 1'b1;
        end else begin
            data_v <= data_left;
            tag_v  <= tag_left;
            stat_v <= stat_left;
        end
    end

    assign mem.data_v   = data_v;
    assign mem.tag_v    = tag_v;
    assign mem.stat_v   = stat_v;
    assign mem.data_pkt = data_pkt;
    assign mem.tag_pkt  = tag_pkt;
    assign mem.stat_pkt = stat_pkt;

endmodule

// File: rtl/bp_l15_fill_encoder.sv
// Collects four 128-bit L1.5 load returns into a cache line for a captured
// miss, then issues data/tag/stat write packets to the cache memories.
module bp_l15_fill_encoder
    import bp_l15_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_i,

    input  logic         miss_v_i,
    input  logic [39:0]  miss_addr_i,
    input  logic [2:0]   lru_way_i,
    output logic         miss_ready_o,

    input  logic         l15_transducer_val,
    input  logic [3:0]   l15_transducer_returntype,
    input  logic [63:0]  l15_transducer_data_0,
    input  logic [63:0]  l15_transducer_data_1,
    output logic         transducer_l15_req_ack,

    output logic [522:0] data_mem_pkt_o,
    output logic         data_mem_pkt_v_o,
    input  logic         data_mem_pkt_yumi_i,
    output logic [41:0]  tag_mem_pkt_o,
    output logic         tag_mem_pkt_v_o,
    input  logic         tag_mem_pkt_yumi_i,
    output logic [10:0]  stat_mem_pkt_o,
    output logic         stat_mem_pkt_v_o,
    input  logic         stat_mem_pkt_yumi_i,

    output logic         fill_done_o
);

    fill_state_e        state;
    logic [1:0]         beat_cnt;
    logic [INDEX_W-1:0] index_r;
    logic [TAG_W-1:0]   tag_r;
    logic [WAY_W-1:0]   way_r;
    logic [LINE_W-1:0]  line_r;

    logic miss_hs;
    logic is_load_ret;
    logic beat_acc;
    logic last_beat;
    logic issue_done;
    logic unused_offset;

    data_mem_pkt_s data_pkt;
    tag_mem_pkt_s  tag_pkt;
    stat_mem_pkt_s stat_pkt;

    bp_l15_fill_encoder_if mem_if ();

    assign unused_offset = ^miss_addr_i[5:0];

    assign miss_ready_o = (state == IDLE) & ~reset_i;
    assign miss_hs      = miss_v_i & miss_ready_o;

    // Non-load returns are always swallowed; load returns stall until a fill is open.
    assign is_load_ret            = (l15_transducer_returntype == LOAD_RET);
    assign transducer_l15_req_ack = l15_transducer_val & ((state == WAIT_DATA) | ~is_load_ret);
    assign beat_acc               = l15_transducer_val & (state == WAIT_DATA) & is_load_ret;
    assign last_beat              = beat_acc & (beat_cnt == 2'd3);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            beat_cnt    <= 2'd0;
            fill_done_o <= 1'b0;
        end else begin
            fill_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_hs) begin
                        state    <= WAIT_DATA;
                        beat_cnt <= 2'd0;
                    end
                end
                WAIT_DATA: begin
                    if (beat_acc) begin
                        beat_cnt <= beat_cnt + 2'd1;
                        if (last_beat) begin
                            state <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (issue_done) begin
                        state       <= IDLE;
                        fill_done_o <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Miss context and line buffer are pure data; only the FSM decides when they load.
    always_ff @(posedge clk_i) begin
        if (miss_hs) begin
            index_r <= miss_addr_i[11:6];
            tag_r   <= miss_addr_i[39:12];
            way_r   <= lru_way_i;
            line_r  <= '0;
        end else if (beat_acc) begin
            line_r[{beat_cnt, 7'd0} +: BEAT_W] <= {l15_transducer_data_1, l15_transducer_data_0};
        end
    end

    always_comb begin
        data_pkt        = '0;
        data_pkt.opcode = DATA_WRITE;
        data_pkt.index  = index_r;
        data_pkt.way    = way_r;
        data_pkt.line   = line_r;

        tag_pkt         = '0;
        tag_pkt.opcode  = TAG_SET;
        tag_pkt.index   = index_r;
        tag_pkt.way     = way_r;
        tag_pkt.state   = COH_E;
        tag_pkt.tag     = tag_r;

        stat_pkt        = '0;
        stat_pkt.opcode = STAT_SET_LRU;
        stat_pkt.index  = index_r;
        stat_pkt.way    = way_r;
    end

    bp_l15_pkt_issue u_issue (
        .clk      (clk_i),
        .rst      (reset_i),
        .start    (last_beat),
        .data_pkt (data_pkt),
        .tag_pkt  (tag_pkt),
        .stat_pkt (stat_pkt),
        .done     (issue_done),
        .mem      (mem_if.master)
    );

    assign mem_if.data_yumi = data_mem_pkt_yumi_i;
    assign mem_if.tag_yumi  = tag_mem_pkt_yumi_i;
    assign mem_if.stat_yumi = stat_mem_pkt_yumi_i;

    assign data_mem_pkt_o   = mem_if.data_pkt;
    assign data_mem_pkt_v_o = mem_if.data_v;
    assign tag_mem_pkt_o    = mem_if.tag_pkt;
    assign tag_mem_pkt_v_o  = mem_if.tag_v;
    assign stat_mem_pkt_o   = mem_if.stat_pkt;
    assign stat_mem_pkt_v_o = mem_if.stat_v;

endmodule

// File: tb/tb_bp_l15_fill_encoder.sv
// Scenario bench for bp_l15_fill_encoder: expected packets are queued as the
// last beat of a fill is driven and compared while the packets are valid.
module tb_bp_l15_fill_encoder;

    logic         clk_i;
    logic         reset_i;
    logic         miss_v_i;
    logic [39:0]  miss_addr_i;
    logic [2:0]   lru_way_i;
    logic         miss_ready_o;
    logic         l15_val;
    logic [3:0]   rtype;
    logic [63:0]  data0;
    logic [63:0]  data1;
    logic         req_ack;
    logic [522:0] dpkt;
    logic         data_v;
    logic         data_yumi;
    logic [41:0]  tpkt;
    logic         tag_v;
    logic         tag_yumi;
    logic [10:0]  spkt;
    logic         stat_v;
    logic         stat_yumi;
    logic         fill_done_o;

    bp_l15_fill_encoder_if mem_if ();

    assign mem_if.data_pkt  = dpkt;
    assign mem_if.data_v    = data_v;
    assign mem_if.data_yumi = data_yumi;
    assign mem_if.tag_pkt   = tpkt;
    assign mem_if.tag_v     = tag_v;
    assign mem_if.tag_yumi  = tag_yumi;
    assign mem_if.stat_pkt  = spkt;
    assign mem_if.stat_v    = stat_v;
    assign mem_if.stat_yumi = stat_yumi;

    bp_l15_fill_encoder dut (
        .clk_i                     (clk_i),
        .reset_i                   (reset_i),
        .miss_v_i                  (miss_v_i),
        .miss_addr_i               (miss_addr_i),
        .lru_way_i                 (lru_way_i),
        .miss_ready_o              (miss_ready_o),
        .l15_transducer_val        (l15_val),
        .l15_transducer_returntype (rtype),
        .l15_transducer_data_0     (data0),
        .l15_transducer_data_1     (data1),
        .transducer_l15_req_ack    (req_ack),
        .data_mem_pkt_o            (dpkt),
        .data_mem_pkt_v_o          (data_v),
        .data_mem_pkt_yumi_i       (data_yumi),
        .tag_mem_pkt_o             (tpkt),
        .tag_mem_pkt_v_o           (tag_v),
        .tag_mem_pkt_yumi_i        (tag_yumi),
        .stat_mem_pkt_o            (spkt),
        .stat_mem_pkt_v_o          (stat_v),
        .stat_mem_pkt_yumi_i       (stat_yumi),
        .fill_done_o               (fill_done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [522:0] d;
        logic [41:0]  t;
        logic [10:0]  s;
    } exp_t;

    exp_t         sb[$];
    int           nchk;
    int           nerr;
    logic [5:0]   e_idx;
    logic [27:0]  e_tag;
    logic [2:0]   e_way;
    logic [511:0] e_line;

    function automatic logic [63:0] pat(input int seed, input int k, input int half);
        return {seed[15:0], 16'hBEEF, 8'(half), 8'(k), 16'hC0DE ^ seed[15:0]};
    endfunction

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic set_miss_exp(input logic [39:0] a, input logic [2:0] w);
        e_idx  = a[11:6];
        e_tag  = a[39:12];
        e_way  = w;
        e_line = '0;
    endtask

    task automatic do_miss(input logic [39:0] a, input logic [2:0] w);
        int n = 0;
        miss_v_i = 1'b1; miss_addr_i = a; lru_way_i = w;
        while (!miss_ready_o && n < 50) begin tick(); n++; end
        nchk++;
        if (miss_ready_o !== 1'b1) begin
            nerr++; $display("FAIL miss_ready_wait got=%b exp=1", miss_ready_o);
        end
        tick();
        miss_v_i = 1'b0;
        set_miss_exp(a, w);
    endtask

    task automatic send_beat(input int seed, input int k);
        logic [63:0] d0;
        logic [63:0] d1;
        exp_t e;
        int n = 0;
        d0 = pat(seed, k, 0);
        d1 = pat(seed, k, 1);
        l15_val = 1'b1; rtype = 4'h0; data0 = d0; data1 = d1;
        #1;
        while (!req_ack && n < 50) begin tick(); #1; n++; end
        nchk++;
        if (req_ack !== 1'b1) begin
            nerr++; $display("FAIL beat%0d_ack got=%b exp=1", k, req_ack);
        end
        tick();
        l15_val = 1'b0;
        e_line[k*128 +: 128] = {d1, d0};
        if (k == 3) begin
            e.d = {2'b01, e_idx, e_way, e_line};
            e.t = {2'b10, e_idx, e_way, 3'b010, e_tag};
            e.s = {2'b11, e_idx, e_way};
            sb.push_back(e);
        end
    endtask

    // Called on the first SEND cycle; yd/ys/yt are the SEND cycles of each yumi.
    task automatic check_send(input int yd, input int ys, input int yt);
        exp_t e;
        logic [2:0] ev;
        int last;
        nchk++;
        if (sb.size() == 0) begin
            nerr++; $display("FAIL scoreboard_empty got=0 exp>0");
            return;
        end
        e = sb.pop_front();
        last = yd;
        if (ys > last) last = ys;
        if (yt > last) last = yt;
        for (int c = 0; c <= last; c++) begin
            ev = {(c <= yd), (c <= yt), (c <= ys)};
            nchk++;
            if ({data_v, tag_v, stat_v} !== ev) begin
                nerr++; $display("FAIL send_valids c=%0d got=%b exp=%b", c, {data_v, tag_v, stat_v}, ev);
            end
            nchk++;
            if (fill_done_o !== 1'b0) begin
                nerr++; $display("FAIL early_done c=%0d got=%b exp=0", c, fill_done_o);
            end
            if (data_v) begin
                nchk++;
                if (dpkt !== e.d) begin
                    nerr++; $display("FAIL data_pkt c=%0d got=%h exp=%h", c, dpkt, e.d);
                end
            end
            if (tag_v) begin
                nchk++;
                if (tpkt !== e.t) begin
                    nerr++; $display("FAIL tag_pkt c=%0d got=%h exp=%h", c, tpkt, e.t);
                end
            end
            if (stat_v) begin
                nchk++;
                if (spkt !== e.s) begin
                    nerr++; $display("FAIL stat_pkt c=%0d got=%h exp=%h", c, spkt, e.s);
                end
            end
            // Yumis stay high after their valid drops; those must be ignored.
            data_yumi = (c >= yd);
            tag_yumi  = (c >= yt);
            stat_yumi = (c >= ys);
            tick();
        end
        data_yumi = 1'b0; tag_yumi = 1'b0; stat_yumi = 1'b0;
        nchk++;
        if (fill_done_o !== 1'b1) begin
            nerr++; $display("FAIL fill_done_pulse got=%b exp=1", fill_done_o);
        end
        nchk++;
        if ({data_v, tag_v, stat_v, miss_ready_o} !== 4'b0001) begin
            nerr++; $display("FAIL after_send got=%b exp=0001", {data_v, tag_v, stat_v, miss_ready_o});
        end
        tick();
        nchk++;
        if (fill_done_o !== 1'b0) begin
            nerr++; $display("FAIL fill_done_width got=%b exp=0", fill_done_o);
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        nchk++;
        if ({miss_ready_o, data_v, tag_v, stat_v, fill_done_o} !== 5'b0) begin
            nerr++; $display("FAIL reset_outputs got=%b exp=00000",
                             {miss_ready_o, data_v, tag_v, stat_v, fill_done_o});
        end
        l15_val = 1'b1; rtype = 4'h0; #1;
        nchk++;
        if (req_ack !== 1'b0) begin nerr++; $display("FAIL reset_ack_load got=%b exp=0", req_ack); end
        rtype = 4'h3; #1;
        nchk++;
        if (req_ack !== 1'b1) begin nerr++; $display("FAIL reset_ack_other got=%b exp=1", req_ack); end
        l15_val = 1'b0; rtype = 4'h0;
        tick();
        reset_i = 1'b0;
        #1;
        nchk++;
        if (miss_ready_o !== 1'b1) begin nerr++; $display("FAIL ready_after_reset got=%b exp=1", miss_ready_o); end
        tick();
    endtask

    task automatic test_basic_fill();
        do_miss(40'h12_3456_7AC0, 3'd5);
        nchk++;
        if ({e_idx, e_tag} !== {6'h2B, 28'h1234567}) begin
            nerr++; $display("FAIL addr_split got=%h exp=%h", {e_idx, e_tag}, {6'h2B, 28'h1234567});
        end
        for (int k = 0; k < 4; k++) send_beat(1, k);
        check_send(0, 0, 0);
    endtask

    task automatic test_staggered_yumi();
        do_miss(40'hAB_CDEF_0140, 3'd2);
        for (int k = 0; k < 4; k++) send_beat(2, k);
        l15_val = 1'b1; rtype = 4'h0; #1;
        nchk++;
        if (req_ack !== 1'b0) begin nerr++; $display("FAIL send_load_backpressure got=%b exp=0", req_ack); end
        l15_val = 1'b0;
        check_send(0, 3, 7);
    endtask

    task automatic test_non_load_ret();
        do_miss(40'h00_0000_1FC0, 3'd7);
        send_beat(3, 0);
        send_beat(3, 1);
        l15_val = 1'b1; rtype = 4'h3; data0 = '1; data1 = '1; #1;
        nchk++;
        if (req_ack !== 1'b1) begin nerr++; $display("FAIL other_ret_ack got=%b exp=1", req_ack); end
        tick();
        l15_val = 1'b0; rtype = 4'h0;
        send_beat(3, 2);
        nchk++;
        if (data_v !== 1'b0) begin nerr++; $display("FAIL early_send got=%b exp=0", data_v); end
        send_beat(3, 3);
        check_send(1, 1, 0);
    endtask

    task automatic test_load_ret_idle();
        logic [63:0] d0;
        logic [63:0] d1;
        d0 = pat(4, 0, 0);
        d1 = pat(4, 0, 1);
        l15_val = 1'b1; rtype = 4'h0; data0 = d0; data1 = d1; #1;
        nchk++;
        if (req_ack !== 1'b0) begin nerr++; $display("FAIL idle_ack got=%b exp=0", req_ack); end
        tick(); #1;
        nchk++;
        if (req_ack !== 1'b0) begin nerr++; $display("FAIL idle_ack_hold got=%b exp=0", req_ack); end
        miss_v_i = 1'b1; miss_addr_i = 40'h55_0000_0C80; lru_way_i = 3'd3;
        tick();
        miss_v_i = 1'b0;
        set_miss_exp(40'h55_0000_0C80, 3'd3);
        #1;
        nchk++;
        if (req_ack !== 1'b1) begin nerr++; $display("FAIL held_beat_ack got=%b exp=1", req_ack); end
        tick();
        l15_val = 1'b0;
        e_line[127:0] = {d1, d0};
        for (int k = 1; k < 4; k++) send_beat(4, k);
        check_send(1, 0, 1);
    endtask

    task automatic test_reset_mid();
        do_miss(40'h77_7777_7040, 3'd1);
        for (int k = 0; k < 3; k++) send_beat(5, k);
        reset_i = 1'b1; #1;
        nchk++;
        if ({miss_ready_o, data_v, tag_v, stat_v, fill_done_o} !== 5'b0) begin
            nerr++; $display("FAIL midreset_outputs got=%b exp=00000",
                             {miss_ready_o, data_v, tag_v, stat_v, fill_done_o});
        end
        l15_val = 1'b1; rtype = 4'h0; #1;
        nchk++;
        if (req_ack !== 1'b0) begin nerr++; $display("FAIL midreset_ack got=%b exp=0", req_ack); end
        l15_val = 1'b0;
        tick();
        reset_i = 1'b0; #1;
        nchk++;
        if (miss_ready_o !== 1'b1) begin nerr++; $display("FAIL midreset_ready got=%b exp=1", miss_ready_o); end
        tick();
        do_miss(40'h31_4159_2E40, 3'd6);
        for (int k = 0; k < 4; k++) send_beat(6, k);
        check_send(2, 1, 0);
    endtask

    task automatic test_miss_in_send();
        do_miss(40'h0F_0F0F_0F00, 3'd4);
        for (int k = 0; k < 4; k++) send_beat(8, k);
        miss_v_i = 1'b1; miss_addr_i = 40'hE0_1234_5FC0; lru_way_i = 3'd2;
        nchk++;
        if (miss_ready_o !== 1'b0) begin nerr++; $display("FAIL send_ready got=%b exp=0", miss_ready_o); end
        check_send(2, 2, 2);
        nchk++;
        if (miss_ready_o !== 1'b0) begin nerr++; $display("FAIL idle_capture got=%b exp=0", miss_ready_o); end
        miss_v_i = 1'b0;
        set_miss_exp(40'hE0_1234_5FC0, 3'd2);
        for (int k = 0; k < 4; k++) send_beat(9, k);
        check_send(0, 2, 1);
    endtask

    initial begin
        nchk = 0; nerr = 0;
        reset_i = 1'b1;
        miss_v_i = 1'b0; miss_addr_i = '0; lru_way_i = '0;
        l15_val = 1'b0; rtype = 4'h0; data0 = '0; data1 = '0;
        data_yumi = 1'b0; tag_yumi = 1'b0; stat_yumi = 1'b0;
        test_reset();
        test_basic_fill();
        test_staggered_yumi();
        test_non_load_ret();
        test_load_ret_idle();
        test_reset_mid();
        test_miss_in_send();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
